// File: rtl/tdc_calctl_pkg.sv
// Shared definitions for the TDC calibration controller: FSM encodings,
// CSR register indices and bit positions (mirrored by the software headers).
package tdc_calctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUIET   = 3'd1,
    S_SETTLE  = 3'd2,
    S_START   = 3'd3,
    S_RUN     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_TMO    = 3'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  localparam logic [23:0] TMO_RESET = 24'hFFFFFF;

  function automatic logic [31:0] status_word(input logic busy, input logic done,
                                              input logic timeout, input logic [7:0] count);
    return {16'd0, count, 5'd0, timeout, done, busy};
  endfunction

endpackage

// File: rtl/tdc_calctl_if.sv
// CSR bus shared by all slaves on the page-decoded control bus.
interface tdc_calctl_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/tdc_calctl_timer.sv
// Periodic calibration down-counter: load takes priority, expire is a
// single-cycle pulse on the PERIOD-th enabled cycle after a load.
module tdc_calctl_timer (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        expire
);

  logic [31:0] cnt_reg;

  assign expire = enable && !load && (cnt_reg == 32'd1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= period;
    end else if (enable) begin
      // An enabled counter sitting at 0 has never been loaded; reload it.
      cnt_reg <= (cnt_reg <= 32'd1) ? period : cnt_reg - 32'd1;
    end
  end

endmodule

// File: rtl/tdc_calctl.sv
// TDC calibration controller: quiesces the channel, runs the ring oscillator,
// pulses cal_start, waits for done or timeout, then releases in order.
module tdc_calctl
  import tdc_calctl_pkg::*;
#(
  parameter logic [3:0]  csr_addr = 4'h2,
  parameter logic [15:0] settle   = 16'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  tdc_calctl_if.slave csr,
  input  logic        tdc_busy_i,
  input  logic        cal_done_i,
  output logic        osc_en_o,
  output logic        cal_sel_o,
  output logic        cal_start_o,
  output logic        irq
);

  state_t      state_reg;
  logic        auto_reg, irqen_reg, done_reg, timeout_reg;
  logic [31:0] period_reg;
  logic [23:0] tmo_reg, run_cnt_reg;
  logic [15:0] settle_cnt_reg;
  logic [7:0]  count_reg;

  logic        sel;
  logic [2:0]  idx;
  logic        wr_ctrl, wr_period, wr_status, wr_tmo;
  logic        busy, request, period_expire, timer_load, timer_en;
  logic [31:0] timer_period, rdata;
  logic        run_done, run_timeout;

  assign sel       = (csr.csr_a[13:10] == csr_addr);
  assign idx       = csr.csr_a[2:0];
  assign wr_ctrl   = sel && csr.csr_we && (idx == REG_CTRL);
  assign wr_period = sel && csr.csr_we && (idx == REG_PERIOD);
  assign wr_status = sel && csr.csr_we && (idx == REG_STATUS);
  assign wr_tmo    = sel && csr.csr_we && (idx == REG_TMO);

  // Manual and periodic requests merge into one; both are dropped while busy.
  assign busy    = (state_reg != S_IDLE);
  assign request = !busy && ((wr_ctrl && csr.csr_di[CTRL_START]) || period_expire);

  assign timer_load   = busy || wr_period;
  assign timer_en     = !busy && auto_reg && (period_reg != 32'd0);
  assign timer_period = wr_period ? csr.csr_di : period_reg;

  tdc_calctl_timer u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (timer_load),
    .enable  (timer_en),
    .period  (timer_period),
    .expire  (period_expire)
  );

  // Done has priority over a timeout landing in the same cycle.
  assign run_done    = (state_reg == S_RUN) && cal_done_i;
  assign run_timeout = (state_reg == S_RUN) && !cal_done_i && (tmo_reg != 24'd0) &&
                       (run_cnt_reg == tmo_reg - 24'd1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= S_IDLE;
      osc_en_o       <= 1'b0;
      cal_sel_o      <= 1'b0;
      cal_start_o    <= 1'b0;
      settle_cnt_reg <= '0;
      run_cnt_reg    <= '0;
    end else begin
      cal_start_o <= 1'b0;
      unique case (state_reg)
        S_IDLE: if (request) state_reg <= S_QUIET;
        S_QUIET: begin
          if (!tdc_busy_i) begin
            osc_en_o       <= 1'b1;
            cal_sel_o      <= 1'b1;
            settle_cnt_reg <= '0;
            state_reg      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_reg == settle - 16'd1) begin
            cal_start_o <= 1'b1;
            state_reg   <= S_START;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 16'd1;
          end
        end
        S_START: begin
          run_cnt_reg <= '0;
          state_reg   <= S_RUN;
        end
        S_RUN: begin
          if (run_done || run_timeout) begin
            cal_sel_o <= 1'b0;
            state_reg <= S_RELEASE;
          end else begin
            run_cnt_reg <= run_cnt_reg + 24'd1;
          end
        end
        S_RELEASE: begin
          osc_en_o  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (idx)
        REG_CTRL:   rdata = {29'd0, irqen_reg, auto_reg, 1'b0};
        REG_PERIOD: rdata = period_reg;
        REG_STATUS: rdata = status_word(busy, done_reg, timeout_reg, count_reg);
        REG_TMO:    rdata = {8'd0, tmo_reg};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      auto_reg    <= 1'b0;
      irqen_reg   <= 1'b0;
      period_reg  <= '0;
      tmo_reg     <= TMO_RESET;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      count_reg   <= '0;
      irq         <= 1'b0;
      csr.csr_do  <= '0;
    end else begin
      if (wr_ctrl) begin
        auto_reg  <= csr.csr_di[CTRL_AUTO];
        irqen_reg <= csr.csr_di[CTRL_IRQEN];
      end
      if (wr_period) period_reg <= csr.csr_di;
      if (wr_tmo) tmo_reg <= csr.csr_di[23:0];
      done_reg    <= run_done || (done_reg && !(wr_status && csr.csr_di[ST_DONE]));
      timeout_reg <= run_timeout || (timeout_reg && !(wr_status && csr.csr_di[ST_TIMEOUT]));
      if (run_done) count_reg <= count_reg + 8'd1;
      irq        <= irqen_reg && (done_reg || timeout_reg);
      csr.csr_do <= rdata;
    end
  end

endmodule

// File: doc/tdc_calctl.md
TDC_CALCTL -- requirements
Module: tdc_calctl

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h2: CSR page; selected when csr_a[13:10]==csr_addr.
REQ-002 SHALL have parameter settle, default 16'd1024: sys_clk cycles the ring oscillator runs before a calibration starts.
REQ-003 SHALL have port sys_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port csr_a, input, 14: CSR address; register index is csr_a[2:0].
REQ-006 SHALL have port csr_we, input, 1: CSR write strobe.
REQ-007 SHALL have port csr_di, input, 32: CSR write data.
REQ-008 SHALL have port csr_do, output, 32: registered CSR read data; 0 when the page is not selected (the bus ORs all slaves).
REQ-009 SHALL have port tdc_busy_i, input, 1: TDC channel is capturing an event.
REQ-010 SHALL have port cal_done_i, input, 1: one-cycle pulse from the TDC when calibration has finished.
REQ-011 SHALL have port osc_en_o, output, 1: enable for the calibration ring oscillator.
REQ-012 SHALL have port cal_sel_o, output, 1: 1 routes the calibration clock to the TDC input.
REQ-013 SHALL have port cal_start_o, output, 1: one-cycle calibration start pulse to the TDC.
REQ-014 SHALL have port irq, output, 1: level interrupt.

Function
REQ-015 SHALL implement these registers: 0 CTRL (bit0 START write-1 self-clearing, bit1 AUTO, bit2 IRQEN); 1 PERIOD[31:0]; 2 STATUS (bit0 BUSY, bit1 DONE sticky, bit2 TIMEOUT sticky, [15:8] COUNT); 3 TMO[23:0].
REQ-016 SHALL write STATUS as write-1-to-clear on bits 1-2; writes to BUSY and COUNT are ignored.
REQ-017 SHALL return read data on csr_do one cycle after the address is applied; CTRL bit0 always reads 0.
REQ-018 SHALL use this FSM: IDLE -> QUIET -> SETTLE -> START -> RUN -> RELEASE -> IDLE.
REQ-019 SHALL leave IDLE on a request, which is a START write or periodic expiry; a manual and a periodic request in the same cycle cause one calibration.
REQ-020 SHALL stay in QUIET while tdc_busy_i=1; on the first cycle tdc_busy_i=0 it asserts osc_en_o and cal_sel_o and enters SETTLE.
REQ-021 SHALL stay in SETTLE for exactly settle cycles, then spend one cycle in START with cal_start_o=1, then enter RUN.
REQ-022 SHALL in RUN count cycles up to TMO; cal_done_i moves to RELEASE, sets DONE and increments COUNT (8-bit, wraps 255->0).
REQ-023 SHALL, when the RUN count reaches TMO, set TIMEOUT and go to RELEASE; TMO=0 disables the timeout; if cal_done_i arrives in the timeout cycle, done wins.
REQ-024 SHALL in RELEASE deassert cal_sel_o, then deassert osc_en_o one cycle later, and return to IDLE.
REQ-025 SHALL ignore cal_done_i outside RUN.
REQ-026 SHALL ignore a START write while BUSY; BUSY=1 in every state except IDLE.
REQ-027 SHALL run the periodic counter only in IDLE with AUTO=1 and PERIOD!=0; it reloads on leaving IDLE and on any PERIOD write, and expires after PERIOD idle cycles.
REQ-028 SHALL drive irq = IRQEN & (DONE | TIMEOUT), registered.

Reset
REQ-029 SHALL on sys_rst clear all outputs to 0, enter IDLE, clear CTRL, STATUS, PERIOD and the counters, and set TMO to 24'hFFFFFF.
REQ-030 SHALL, when sys_rst is asserted mid-calibration, drop osc_en_o, cal_sel_o and cal_start_o on the next edge with no RELEASE sequence.

Structure
REQ-031 SHALL keep the state encodings and register indices in a shared tdc_calctl definitions package/header, which software headers also mirror.
REQ-032 SHALL implement the periodic down-counter as sub-module tdc_calctl_timer (load, enable, expire).

Verification
REQ-033 SHALL cover: START write, tdc_busy_i=0, cal_done_i 50 cycles after cal_start_o -> cal_start_o 1025 cycles after the write; DONE=1; COUNT=1; irq=1 only if IRQEN.
REQ-034 SHALL cover: tdc_busy_i held high for 200 cycles after START -> osc_en_o stays 0 until tdc_busy_i falls, then SETTLE runs its full length.
REQ-035 SHALL cover: TMO=100 with no cal_done_i -> TIMEOUT=1 at 100 RUN cycles; cal_sel_o drops, then osc_en_o one cycle later; COUNT unchanged.
REQ-036 SHALL cover: AUTO=1, PERIOD=5000 -> calibrations start every 5000 idle cycles; a PERIOD write mid-count restarts the count.
REQ-037 SHALL cover: sys_rst asserted in RUN -> all outputs 0 and STATUS=0 on the next cycle; a cal_done_i after reset leaves COUNT unchanged.
REQ-038 SHALL cover: 256 successful calibrations -> COUNT wraps to 0; a read with csr_a[13:10]!=csr_addr -> csr_do=0.
